countdown_timer: RTL



---
 rtl/countdown_timer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: preset/start/pause countdown feeding the display driver.
// Buttons are synchronised, debounced and edge-detected locally.
module countdown_timer #(
  parameter int TICK_DIV        = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw_preset,
  input  logic       btn_start,
  input  logic       btn_load,
  output logic [7:0] num_out,
  output logic       running,
  output logic       done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    lvl;
  logic [1:0]    lvl_d;
  logic [1:0]    press;
  logic [DW-1:0] db_cnt [2];
  logic [7:0]    sw_q;
  logic [7:0]    value;
  logic [PW-1:0] presc;
  logic          start_ev;
  logic          load_ev;
  logic          tick;

  // bit 0 is start, bit 1 is load
  assign raw      = {btn_load, btn_start};
  assign press    = lvl & ~lvl_d;
  assign load_ev  = press[1];
  assign start_ev = press[0] & ~press[1];
  assign tick     = (presc == TICK_MAX);
  assign num_out  = value;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_d <= lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          lvl[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    if (load_ev) begin
      state_n = IDLE;
    end else if (start_ev) begin
      unique case (state)
        IDLE:    state_n = (sw_q == 8'd0) ? DONE : RUN;
        RUN:     state_n = PAUSE;
        PAUSE:   state_n = RUN;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end else if (state == RUN && tick && value <= 8'd1) begin
      state_n = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      sw_q    <= '0;
      value   <= '0;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      sw_q    <= sw_preset;
      state   <= state_n;
      running <= (state_n == RUN);
      done    <= (state_n == DONE);
      if (load_ev) begin
        presc <= '0;
        value <= sw_q;
      end else begin
        unique case (state)
          IDLE: begin
            value <= sw_q;
            if (start_ev) presc <= '0;
          end
          RUN: begin
            if (!start_ev) begin
              if (tick) begin
                presc <= '0;
                if (value != 8'd0) value <= value - 8'd1;
              end else begin
                presc <= presc + PW'(1);
              end
            end
          end
          PAUSE: begin
            value <= value;
          end
          DONE: begin
            value <= '0;
          end
          default: begin
            value <= '0;
          end
        endcase
      end
    end
  end

endmodule
